tile_cfg_mem_rx: RTL and testbench
==================================

// Module: tile_cfg_mem_rx
// PURPOSE
//  Tile-side receiver for the CSR-to-tile configuration write interface (addr/data/wr_en/wr_valid/ready).
//  Stores KernelSize configuration words per tile and tracks which context slots have been written.
//  Once every slot is loaded and execution starts, replays the stored words cyclically to the tile FU/crossbar.
//  One instance per CGRA tile, sitting between the CSR block and the tile datapath.
// PARAMETERS
//  KernelSize   4                       number of configuration contexts per tile
//  ConfigWidth  49                      config word width: ctrl 6 | predicate 1 | fu_in 12 | outport 24 | predicate_in 6
//  CtxAddrWidth $clog2(KernelSize)      context address width
//  IterWidth    16                      kernel iteration counter width
// PORTS
//  clk_i           in   1             clock
//  rst_ni          in   1             asynchronous active-low reset
//  cfg_addr_i      in   CtxAddrWidth  context slot to write
//  cfg_data_i      in   ConfigWidth   configuration word
//  cfg_wr_en_i     in   1             write enable (qualifies a valid beat as a write)
//  cfg_wr_valid_i  in   1             beat valid
//  cfg_ready_o     out  1             receiver can accept a beat
//  clear_i         in   1             sync clear: invalidate all slots, return to IDLE
//  exec_start_i    in   1             start cyclic replay (pulse)
//  exec_stop_i     in   1             stop replay (pulse)
//  exec_stall_i    in   1             hold current context
//  cfg_o           out  ConfigWidth   active configuration word
//  cfg_valid_o     out  1             cfg_o is valid (state RUN)
//  ctx_idx_o       out  CtxAddrWidth  active context index
//  iter_cnt_o      out  IterWidth     completed kernel iterations since start
//  loaded_o        out  1             all KernelSize slots written since last clear
//  err_o           out  2             sticky: [0] beat dropped, [1] start while not loaded
// BEHAVIOUR
//  Reset: state IDLE, memory and slot mask zero, ctx 0, iter 0, err 0; cfg_o=0, cfg_valid_o=0, loaded_o=0, cfg_ready_o=1.
//  FSM states: IDLE (mask empty), LOAD (mask partial), READY (mask full), RUN.
//  cfg_ready_o = (state != RUN); combinational from state only, not dependent on valid.
//  Beat accepted when cfg_wr_valid_i & cfg_wr_en_i & cfg_ready_o & (cfg_addr_i < KernelSize).
//   Accepted beat: mem[addr] <= data and mask[addr] <= 1 at the next edge. Rewriting a slot overwrites it.
//  Valid beat without wr_en: no-op, no error.
//  Valid+wr_en beat while ready is low, or with addr >= KernelSize: dropped, err_o[0] set. The sender does not wait for ready.
//  loaded_o = &mask (registered). Transitions:
//   IDLE->LOAD on first write. LOAD->READY when the mask becomes full; READY is entered on the edge that writes the last slot.
//  READY & exec_start_i -> RUN. On entry: ctx=0, iter=0.
//   A write accepted in the same cycle as the start is stored and is visible in RUN.
//  exec_start_i outside READY: ignored. If the mask is not full, err_o[1] is set.
//  RUN, each cycle:
//   - exec_stop_i: go to READY, ctx and iter hold. Stop wins over stall and over start.
//   - else exec_stall_i: ctx and iter hold.
//   - else ctx advances by 1. At ctx = KernelSize-1 it wraps to 0 and iter increments (wraps at 2^IterWidth).
//  cfg_o = mem[ctx] combinationally from registered ctx while RUN, otherwise 0. Zero latency after the RUN entry edge.
//  cfg_valid_o = (state == RUN); ctx_idx_o = ctx; iter_cnt_o = iter.
//  clear_i, any state, highest priority:
//   - next state IDLE, mask=0, ctx=0, iter=0, err=0; mem contents retained.
//   - A beat presented with clear is dropped without setting an error.
//  Mid-operation asynchronous reset: all state returns to reset values immediately; stored config is lost.
// TESTING
//  - Reset then write slots 0..3 (data 'h1..'h4) -> loaded_o rises after 4th edge, state READY, err_o=0.
//  - Load all, start, no stall -> cfg_o sequence 1,2,3,4,1,...; iter_cnt_o=1 after the 4th RUN cycle.
//  - In RUN, assert stall 3 cycles at ctx=2 -> cfg_o holds 'h3; stop+stall together -> cfg_valid_o=0 next cycle.
//  - Write slot 1 during RUN -> cfg_ready_o=0, mem unchanged, err_o[0]=1. Start with 3 slots loaded -> stays LOAD, err_o[1]=1.
//  - Write to slot 3 with simultaneous start in READY -> RUN entered, cfg_o at ctx 3 shows the new value.
//  - clear_i in RUN -> IDLE, loaded_o=0, err_o=0; rewrite all 4 slots -> READY again.

Source files
------------

// File: rtl/tile_cfg_mem_rx.sv
// Tile-side configuration receiver: captures per-context config words from the CSR
// write interface and replays them cyclically to the tile datapath once started.
module tile_cfg_mem_rx #(
    parameter int KernelSize   = 4,
    parameter int ConfigWidth  = 49,
    parameter int CtxAddrWidth = $clog2(KernelSize),
    parameter int IterWidth    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [CtxAddrWidth-1:0] cfg_addr_i,
    input  logic [ConfigWidth-1:0]  cfg_data_i,
    input  logic                    cfg_wr_en_i,
    input  logic                    cfg_wr_valid_i,
    output logic                    cfg_ready_o,
    input  logic                    clear_i,
    input  logic                    exec_start_i,
    input  logic                    exec_stop_i,
    input  logic                    exec_stall_i,
    output logic [ConfigWidth-1:0]  cfg_o,
    output logic                    cfg_valid_o,
    output logic [CtxAddrWidth-1:0] ctx_idx_o,
    output logic [IterWidth-1:0]    iter_cnt_o,
    output logic                    loaded_o,
    output logic [1:0]              err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [CtxAddrWidth:0]   SlotCount = (CtxAddrWidth + 1)'(KernelSize);
    localparam logic [CtxAddrWidth-1:0] LastCtx   = CtxAddrWidth'(KernelSize - 1);

    state_t                  state, state_next;
    logic [ConfigWidth-1:0]  mem [KernelSize];
    logic [KernelSize-1:0]   mask, mask_next;
    logic [CtxAddrWidth-1:0] ctx, ctx_next;
    logic [IterWidth-1:0]    iter, iter_next;
    logic [1:0]              err, err_next;
    logic                    beat, addr_ok, accept, drop, start_err;

    assign cfg_ready_o = (state != RUN);
    assign cfg_valid_o = (state == RUN);
    assign ctx_idx_o   = ctx;
    assign iter_cnt_o  = iter;
    assign loaded_o    = &mask;
    assign err_o       = err;

    always_comb begin
        cfg_o = '0;
        if (state == RUN) begin
            cfg_o = mem[ctx];
        end
    end

    // Write acceptance; clear swallows any beat in its cycle without flagging it.
    always_comb begin
        beat      = cfg_wr_valid_i & cfg_wr_en_i;
        addr_ok   = ({1'b0, cfg_addr_i} < SlotCount);
        accept    = beat & cfg_ready_o & addr_ok & ~clear_i;
        drop      = beat & ~clear_i & (~cfg_ready_o | ~addr_ok);
        start_err = exec_start_i & ~clear_i & (state != READY) & ~(&mask);
        mask_next = mask;
        if (accept) begin
            mask_next[cfg_addr_i] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        ctx_next   = ctx;
        iter_next  = iter;
        err_next   = err | {start_err, drop};
        if (clear_i) begin
            state_next = IDLE;
            ctx_next   = '0;
            iter_next  = '0;
            err_next   = '0;
        end else begin
            unique case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        state_next = (&mask_next) ? READY : LOAD;
                    end
                end
                READY: begin
                    if (exec_start_i && !exec_stop_i) begin
                        state_next = RUN;
                        ctx_next   = '0;
                        iter_next  = '0;
                    end
                end
                RUN: begin
                    if (exec_stop_i) begin
                        state_next = READY;
                    end else if (!exec_stall_i) begin
                        if (ctx == LastCtx) begin
                            ctx_next  = '0;
                            iter_next = iter + IterWidth'(1);
                        end else begin
                            ctx_next = ctx + CtxAddrWidth'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            mask  <= '0;
            ctx   <= '0;
            iter  <= '0;
            err   <= '0;
        end else begin
            state <= state_next;
            mask  <= clear_i ? '0 : mask_next;
            ctx   <= ctx_next;
            iter  <= iter_next;
            err   <= err_next;
        end
    end

    // Storage survives clear_i but not reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < KernelSize; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[cfg_addr_i] <= cfg_data_i;
        end
    end

endmodule

// File: tb/tb_tile_cfg_mem_rx.sv
// Directed self-checking bench for tile_cfg_mem_rx: load, replay, stall/stop,
// dropped beats, partial-load start, write-with-start, clear and async reset.
module tb_tile_cfg_mem_rx;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  cfg_addr_i = '0;
    logic [48:0] cfg_data_i = '0;
    logic        cfg_wr_en_i = 1'b0;
    logic        cfg_wr_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic        clear_i = 1'b0;
    logic        exec_start_i = 1'b0;
    logic        exec_stop_i = 1'b0;
    logic        exec_stall_i = 1'b0;
    logic [48:0] cfg_o;
    logic        cfg_valid_o;
    logic [1:0]  ctx_idx_o;
    logic [15:0] iter_cnt_o;
    logic        loaded_o;
    logic [1:0]  err_o;

    int checks = 0;
    int errors = 0;

    tile_cfg_mem_rx dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
        .cfg_wr_en_i(cfg_wr_en_i), .cfg_wr_valid_i(cfg_wr_valid_i),
        .cfg_ready_o(cfg_ready_o), .clear_i(clear_i),
        .exec_start_i(exec_start_i), .exec_stop_i(exec_stop_i), .exec_stall_i(exec_stall_i),
        .cfg_o(cfg_o), .cfg_valid_o(cfg_valid_o), .ctx_idx_o(ctx_idx_o),
        .iter_cnt_o(iter_cnt_o), .loaded_o(loaded_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic write_beat(input logic [1:0] addr, input logic [48:0] data,
                              input logic en, input logic start);
        cfg_addr_i = addr; cfg_data_i = data;
        cfg_wr_valid_i = 1'b1; cfg_wr_en_i = en; exec_start_i = start;
        step(1);
        cfg_wr_valid_i = 1'b0; cfg_wr_en_i = 1'b0; exec_start_i = 1'b0;
    endtask

    task automatic pulse_start();
        exec_start_i = 1'b1; step(1); exec_start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        exec_stop_i = 1'b1; step(1); exec_stop_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #22 rst_ni = 1'b1;
        step(1);
        checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 1", cfg_ready_o); end
        checks++; if (cfg_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", cfg_valid_o); end
        checks++; if (loaded_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_loaded: got %0b expected 0", loaded_o); end
        checks++; if (err_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_err: got %0b expected 00", err_o); end
        checks++; if (cfg_o !== 49'h0) begin errors++; $display("[TB] FAIL reset_cfg: got %0h expected 0", cfg_o); end
        checks++; if (ctx_idx_o !== 2'd0 || iter_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL reset_ctx_iter: got ctx %0d iter %0d expected 0 0", ctx_idx_o, iter_cnt_o); end
    endtask

    task automatic test_load();
        write_beat(2'd0, 49'h1, 1'b0, 1'b0);
        checks++; if (loaded_o !== 1'b0 || err_o !== 2'b00) begin errors++; $display("[TB] FAIL valid_no_en: got loaded %0b err %0b expected 0 00", loaded_o, err_o); end
        for (int i = 0; i < 4; i++) begin
            write_beat(2'(i), 49'(i + 1), 1'b1, 1'b0);
            checks++;
            if (loaded_o !== (i == 3)) begin errors++; $display("[TB] FAIL load_slot%0d: got loaded %0b expected %0b", i, loaded_o, (i == 3)); end
        end
        checks++; if (err_o !== 2'b00 || cfg_valid_o !== 1'b0 || cfg_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL load_done: got err %0b valid %0b ready %0b expected 00 0 1", err_o, cfg_valid_o, cfg_ready_o); end
    endtask

    task automatic test_run();
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (cfg_valid_o !== 1'b1 || cfg_o !== 49'((k % 4) + 1) || ctx_idx_o !== 2'(k % 4) || iter_cnt_o !== 16'(k / 4)) begin
                errors++;
                $display("[TB] FAIL run_seq%0d: got valid %0b cfg %0h ctx %0d iter %0d expected 1 %0h %0d %0d",
                         k, cfg_valid_o, cfg_o, ctx_idx_o, iter_cnt_o, (k % 4) + 1, k % 4, k / 4);
            end
            if (k < 5) step(1);
        end
        checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL run_ready: got %0b expected 0", cfg_ready_o); end
        pulse_stop();
        checks++;
        if (cfg_valid_o !== 1'b0 || cfg_o !== 49'h0 || ctx_idx_o !== 2'd1 || iter_cnt_o !== 16'd1) begin
            errors++;
            $display("[TB] FAIL stop_hold: got valid %0b cfg %0h ctx %0d iter %0d expected 0 0 1 1", cfg_valid_o, cfg_o, ctx_idx_o, iter_cnt_o);
        end
    endtask

    task automatic test_stall_stop();
        pulse_start();
        step(2);
        exec_stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            checks++; if (cfg_o !== 49'h3 || ctx_idx_o !== 2'd2) begin errors++; $display("[TB] FAIL stall%0d: got cfg %0h ctx %0d expected 3 2", k, cfg_o, ctx_idx_o); end
        end
        exec_stall_i = 1'b0;
        step(1);
        checks++; if (cfg_o !== 49'h4 || ctx_idx_o !== 2'd3) begin errors++; $display("[TB] FAIL stall_release: got cfg %0h ctx %0d expected 4 3", cfg_o, ctx_idx_o); end
        exec_stall_i = 1'b1;
        pulse_stop();
        exec_stall_i = 1'b0;
        checks++; if (cfg_valid_o !== 1'b0 || ctx_idx_o !== 2'd3) begin errors++; $display("[TB] FAIL stop_stall: got valid %0b ctx %0d expected 0 3", cfg_valid_o, ctx_idx_o); end
    endtask

    task automatic test_run_write();
        pulse_start();
        checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL run_write_ready: got %0b expected 0", cfg_ready_o); end
        write_beat(2'd1, 49'hAA, 1'b1, 1'b0);
        checks++; if (err_o !== 2'b01) begin errors++; $display("[TB] FAIL run_write_err: got %0b expected 01", err_o); end
        checks++; if (cfg_o !== 49'h2 || ctx_idx_o !== 2'd1) begin errors++; $display("[TB] FAIL run_write_mem: got cfg %0h ctx %0d expected 2 1", cfg_o, ctx_idx_o); end
        pulse_stop();
    endtask

    task automatic test_partial_start();
        clear_i = 1'b1; step(1); clear_i = 1'b0;
        checks++; if (err_o !== 2'b00 || loaded_o !== 1'b0) begin errors++; $display("[TB] FAIL clear_ready: got err %0b loaded %0b expected 00 0", err_o, loaded_o); end
        for (int i = 0; i < 3; i++) write_beat(2'(i), 49'(i + 1), 1'b1, 1'b0);
        pulse_start();
        checks++; if (cfg_valid_o !== 1'b0 || err_o !== 2'b10 || loaded_o !== 1'b0) begin errors++; $display("[TB] FAIL partial_start: got valid %0b err %0b loaded %0b expected 0 10 0", cfg_valid_o, err_o, loaded_o); end
        write_beat(2'd3, 49'h4, 1'b1, 1'b0);
        checks++; if (loaded_o !== 1'b1) begin errors++; $display("[TB] FAIL partial_fill: got loaded %0b expected 1", loaded_o); end
    endtask

    task automatic test_write_with_start();
        write_beat(2'd3, 49'h55, 1'b1, 1'b1);
        checks++; if (cfg_valid_o !== 1'b1 || cfg_o !== 49'h1) begin errors++; $display("[TB] FAIL ws_entry: got valid %0b cfg %0h expected 1 1", cfg_valid_o, cfg_o); end
        step(3);
        checks++; if (ctx_idx_o !== 2'd3 || cfg_o !== 49'h55) begin errors++; $display("[TB] FAIL ws_ctx3: got ctx %0d cfg %0h expected 3 55", ctx_idx_o, cfg_o); end
        checks++; if (err_o !== 2'b10) begin errors++; $display("[TB] FAIL ws_sticky: got %0b expected 10", err_o); end
    endtask

    task automatic test_clear();
        clear_i = 1'b1; step(1); clear_i = 1'b0;
        checks++;
        if (cfg_valid_o !== 1'b0 || loaded_o !== 1'b0 || err_o !== 2'b00 || ctx_idx_o !== 2'd0 || iter_cnt_o !== 16'd0 || cfg_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_run: got valid %0b loaded %0b err %0b ctx %0d iter %0d ready %0b expected 0 0 00 0 0 1",
                     cfg_valid_o, loaded_o, err_o, ctx_idx_o, iter_cnt_o, cfg_ready_o);
        end
        for (int i = 0; i < 4; i++) write_beat(2'(i), 49'(16'h11 * (i + 1)), 1'b1, 1'b0);
        checks++; if (loaded_o !== 1'b1 || err_o !== 2'b00) begin errors++; $display("[TB] FAIL clear_reload: got loaded %0b err %0b expected 1 00", loaded_o, err_o); end
        pulse_start();
        step(1);
        checks++; if (cfg_o !== 49'h22) begin errors++; $display("[TB] FAIL clear_replay: got %0h expected 22", cfg_o); end
    endtask

    task automatic test_async_reset();
        #3 rst_ni = 1'b0;
        #1;
        checks++; if (cfg_valid_o !== 1'b0 || loaded_o !== 1'b0 || cfg_o !== 49'h0 || ctx_idx_o !== 2'd0) begin errors++; $display("[TB] FAIL async_reset: got valid %0b loaded %0b cfg %0h ctx %0d expected 0 0 0 0", cfg_valid_o, loaded_o, cfg_o, ctx_idx_o); end
        #2 rst_ni = 1'b1;
        step(1);
        for (int i = 0; i < 4; i++) write_beat(2'(i), 49'h0, 1'b0, 1'b0);
        write_beat(2'd0, 49'h0, 1'b1, 1'b0);
        checks++; if (loaded_o !== 1'b0 || cfg_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_mask: got loaded %0b ready %0b expected 0 1", loaded_o, cfg_ready_o); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run();
        test_stall_stop();
        test_run_write();
        test_partial_start();
        test_write_with_start();
        test_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
